mmio_ctrl: RTL and testbench
============================

// Module: mmio_ctrl
// PURPOSE
//   Memory-mapped I/O controller downstream of the data-memory address path.
//   - Decodes CPU load/store accesses to the KEY, SW, HEX, LEDR and LEDG addresses.
//   - Holds the output registers that drive the HEX digits and the LEDs.
//   - Synchronises and debounces the raw KEY and SW inputs.
//   - Records sticky key-press events so software can poll them without missing presses.
// PARAMETERS
//   DBITS            32            data/address width
//   ADDR_HEX         32'hF0000000  HEX register (RW, bits[15:0])
//   ADDR_LEDR        32'hF0000004  LEDR register (RW, bits[9:0])
//   ADDR_LEDG        32'hF0000008  LEDG register (RW, bits[7:0])
//   ADDR_KEY         32'hF0000010  KEY register (RO; read clears press flags)
//   ADDR_SW          32'hF0000014  SW register (RO, bits[9:0])
//   DEBOUNCE_CYCLES  50000         consecutive stable samples before an input bit is accepted
// PORTS
//   clk       in   1      system clock (PLL c0)
//   reset     in   1      asynchronous, active-low reset
//   we        in   1      store strobe from the CPU, qualified by addr
//   re        in   1      load strobe from the CPU, qualified by addr
//   addr      in   DBITS  byte address of the access
//   wdata     in   DBITS  store data
//   sel       out  1      combinational; 1 when addr matches one of the five I/O addresses
//   rdata     out  DBITS  registered load data
//   key_in    in   4      raw KEY pins; a pin reads 0 while its key is pressed
//   sw_in     in   10     raw SW pins
//   hex_out   out  16     four 4-bit digit codes, to the 7-segment decoders
//   ledr_out  out  10     red LEDs
//   ledg_out  out  8      green LEDs
// BEHAVIOUR
//   Reset
//   - reset=0 asynchronously clears: rdata, hex_out, ledr_out, ledg_out, the sync flops,
//     the debounce counters, the debounced state and the press flags.
//   - The debounced key state clears to "not pressed"; the debounced SW state clears to 0.
//   - Reset asserted mid-operation aborts any debounce in progress. No press is reported
//     for a key that is held down through reset until its debounce completes.
//   Input path
//   - Every key_in and sw_in bit passes through a 2-flop synchroniser.
//   - key_in is inverted after synchronisation, so 1 = pressed.
//   - Each of the 14 bits has its own counter.
//     - While the synchronised value differs from the debounced value, the counter increments.
//     - It reloads to 0 on any cycle where the two values are equal.
//     - When it reaches DEBOUNCE_CYCLES-1, the debounced value takes the new value and the
//       counter returns to 0.
//     - Counter width is $clog2(DEBOUNCE_CYCLES)+1; the counter never wraps.
//   - A 0->1 transition of debounced key bit i sets press_flag[i].
//   Write path (takes effect on the clk edge where we=1)
//   - ADDR_HEX: hex_out <= wdata[15:0].
//   - ADDR_LEDR: ledr_out <= wdata[9:0].
//   - ADDR_LEDG: ledg_out <= wdata[7:0].
//   - Writes to ADDR_KEY, ADDR_SW or any unmapped address have no effect.
//   - Upper wdata bits are ignored.
//   Read path
//   - Latency is 1 cycle: rdata is valid on the cycle after the edge that samples re=1.
//   - ADDR_HEX, ADDR_LEDR, ADDR_LEDG: the corresponding register, zero-extended.
//   - ADDR_KEY: {24'b0, press_flag[3:0], key_db[3:0]}.
//   - ADDR_SW: {22'b0, sw_db[9:0]}.
//   - Unmapped address: 0.
//   - When re=0, rdata holds its previous value.
//   - A read of ADDR_KEY clears press_flag on the same edge that captures the value into rdata.
//   - If a new press edge and a KEY read land on the same edge, rdata shows the old flags
//     and the flag for the new press stays set (set wins over clear).
//   - If we and re are both 1 to the same RW address, rdata returns the value held before
//     the write; the write completes.
// TESTING (bench sets DEBOUNCE_CYCLES=4)
//   1 Reset: drive reset=0 mid-run with hex_out=16'h1234 -> all outputs are 0 immediately
//     (asynchronous); read ADDR_KEY after release -> 32'h0.
//   2 Store and load: write 32'hFFFFABCD to ADDR_HEX, 0x3FF to ADDR_LEDR, 0x1A5 to ADDR_LEDG
//     -> hex_out=ABCD, ledr_out=3FF, ledg_out=A5; reads return 0xABCD, 0x3FF, 0xA5
//     one cycle after re.
//   3 Debounce: toggle key_in[0] low for 3 cycles -> key_db and press_flag unchanged;
//     hold it low for 10 cycles -> key_db[0]=1 exactly 2+4 cycles after the pin settles;
//     read ADDR_KEY -> 32'h11; read again -> 32'h01.
//   4 Set wins over clear: complete the debounce of key_in[2] on the same edge as a KEY read
//     -> that read returns bit 6 = 0; the next read returns 32'h44.
//   5 Switches and decode: set sw_in=10'h2AA, wait 8 cycles, read ADDR_SW -> 32'h2AA;
//     read 32'hF000000C -> sel=0, rdata=0; write ADDR_SW -> no state change.

Source files
------------

// File: rtl/mmio_ctrl_if.sv
// CPU-side load/store bus into the memory-mapped I/O controller.
interface mmio_ctrl_if #(
  parameter int unsigned DBITS = 32
);
  logic             we;
  logic             re;
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             sel;
  logic [DBITS-1:0] rdata;

  modport master (output we, re, addr, wdata, input sel, rdata);
  modport slave  (input we, re, addr, wdata, output sel, rdata);
endinterface

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: HEX/LED output registers, debounced KEY/SW inputs
// and sticky key-press flags that are cleared by a KEY read.
module mmio_ctrl #(
  parameter int unsigned     DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX       = DBITS'(32'hF000_0000),
  parameter logic [DBITS-1:0] ADDR_LEDR      = DBITS'(32'hF000_0004),
  parameter logic [DBITS-1:0] ADDR_LEDG      = DBITS'(32'hF000_0008),
  parameter logic [DBITS-1:0] ADDR_KEY       = DBITS'(32'hF000_0010),
  parameter logic [DBITS-1:0] ADDR_SW        = DBITS'(32'hF000_0014),
  parameter int unsigned     DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  mmio_ctrl_if.slave   bus,
  input  logic [3:0]   key_in,
  input  logic [9:0]   sw_in,
  output logic [15:0]  hex_out,
  output logic [9:0]   ledr_out,
  output logic [7:0]   ledg_out
);

  localparam int unsigned NKEY = 4;
  localparam int unsigned NSW  = 10;
  localparam int unsigned NIN  = NKEY + NSW;
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] in_sync_c;
  logic [NIN-1:0] db;
  logic [NIN-1:0] diff_c;
  logic [NIN-1:0] accept_c;
  logic [CW-1:0]  cnt       [NIN];
  logic [CW-1:0]  cnt_nxt_c [NIN];

  logic [NKEY-1:0] key_db;
  logic [NSW-1:0]  sw_db;
  logic [NKEY-1:0] press_flag;
  logic [NKEY-1:0] press_set_c;
  logic            key_clr_c;

  logic hit_hex_c, hit_ledr_c, hit_ledg_c, hit_key_c, hit_sw_c;
  logic [DBITS-1:0] rd_mux_c;
  logic             unused_wdata_c;

  // Two-flop synchroniser on the raw pins; keys are active-low at the pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sw_in, key_in};
      sync2 <= sync1;
    end
  end

  assign in_sync_c = {sync2[NIN-1:NKEY], ~sync2[NKEY-1:0]};

  // Per-bit stability counter; a bit is accepted after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    diff_c   = '0;
    accept_c = '0;
    for (int i = 0; i < int'(NIN); i++) begin
      cnt_nxt_c[i] = '0;
      diff_c[i]    = in_sync_c[i] != db[i];
      accept_c[i]  = diff_c[i] && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      if (diff_c[i] && !accept_c[i]) begin
        cnt_nxt_c[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NIN); i++) begin
        cnt[i] <= '0;
      end
      db <= '0;
    end else begin
      for (int i = 0; i < int'(NIN); i++) begin
        cnt[i] <= cnt_nxt_c[i];
      end
      db <= (db & ~accept_c) | (in_sync_c & accept_c);
    end
  end

  assign key_db = db[NKEY-1:0];
  assign sw_db  = db[NIN-1:NKEY];

  // Address decode; only exact matches select a register.
  assign hit_hex_c  = bus.addr == ADDR_HEX;
  assign hit_ledr_c = bus.addr == ADDR_LEDR;
  assign hit_ledg_c = bus.addr == ADDR_LEDG;
  assign hit_key_c  = bus.addr == ADDR_KEY;
  assign hit_sw_c   = bus.addr == ADDR_SW;
  assign bus.sel    = hit_hex_c | hit_ledr_c | hit_ledg_c | hit_key_c | hit_sw_c;

  // A debounced 0->1 key edge sets its flag; set has priority over the read-clear.
  assign press_set_c = accept_c[NKEY-1:0] & in_sync_c[NKEY-1:0];
  assign key_clr_c   = bus.re & hit_key_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_flag <= '0;
    end else begin
      press_flag <= (press_flag & ~{NKEY{key_clr_c}}) | press_set_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_out  <= '0;
      ledr_out <= '0;
      ledg_out <= '0;
    end else if (bus.we) begin
      if (hit_hex_c)  hex_out  <= bus.wdata[15:0];
      if (hit_ledr_c) ledr_out <= bus.wdata[9:0];
      if (hit_ledg_c) ledg_out <= bus.wdata[7:0];
    end
  end

  assign unused_wdata_c = ^bus.wdata[DBITS-1:16];

  // Load data reflects register contents before any same-edge write.
  always_comb begin
    rd_mux_c = '0;
    if (hit_hex_c)  rd_mux_c = DBITS'(hex_out);
    if (hit_ledr_c) rd_mux_c = DBITS'(ledr_out);
    if (hit_ledg_c) rd_mux_c = DBITS'(ledg_out);
    if (hit_key_c)  rd_mux_c = DBITS'({press_flag, key_db});
    if (hit_sw_c)   rd_mux_c = DBITS'(sw_db);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata <= '0;
    end else if (bus.re) begin
      bus.rdata <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with a short debounce window.
module tb_mmio_ctrl;

  localparam int unsigned DBITS = 32;
  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;
  localparam logic [31:0] A_GAP  = 32'hF000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;
  logic [7:0]  ledg_out;

  int n_cmp = 0;
  int n_err = 0;

  mmio_ctrl_if #(.DBITS(DBITS)) bus ();

  mmio_ctrl #(.DBITS(DBITS), .DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .key_in   (key_in),
    .sw_in    (sw_in),
    .hex_out  (hex_out),
    .ledr_out (ledr_out),
    .ledg_out (ledg_out)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.re = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_write(A_HEX, 32'h1234);
    bus_write(A_LEDR, 32'h155);
    bus_write(A_LEDG, 32'h3C);
    bus_read(A_HEX, d);
    #2 reset = 1'b0;
    #1;
    if ({hex_out, ledr_out, ledg_out} !== 34'h0) begin
      n_err++; $display("FAIL reset_outputs: got hex=%h ledr=%h ledg=%h, want 0", hex_out, ledr_out, ledg_out);
    end
    n_cmp++;
    if (bus.rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h, want 0", bus.rdata);
    end
    n_cmp++;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(A_KEY, d);
    if (d !== 32'h0) begin
      n_err++; $display("FAIL reset_key_read: got %h, want 00000000", d);
    end
    n_cmp++;
  endtask

  task automatic test_store_load();
    logic [31:0] d;
    bus_write(A_HEX, 32'hFFFF_ABCD);
    bus_write(A_LEDR, 32'h3FF);
    bus_write(A_LEDG, 32'h1A5);
    if (hex_out !== 16'hABCD) begin
      n_err++; $display("FAIL hex_out: got %h, want abcd", hex_out);
    end
    n_cmp++;
    if (ledr_out !== 10'h3FF) begin
      n_err++; $display("FAIL ledr_out: got %h, want 3ff", ledr_out);
    end
    n_cmp++;
    if (ledg_out !== 8'hA5) begin
      n_err++; $display("FAIL ledg_out: got %h, want a5", ledg_out);
    end
    n_cmp++;
    bus_read(A_HEX, d);
    if (d !== 32'hABCD) begin
      n_err++; $display("FAIL read_hex: got %h, want 0000abcd", d);
    end
    n_cmp++;
    bus_read(A_LEDR, d);
    if (d !== 32'h3FF) begin
      n_err++; $display("FAIL read_ledr: got %h, want 000003ff", d);
    end
    n_cmp++;
    bus_read(A_LEDG, d);
    if (d !== 32'hA5) begin
      n_err++; $display("FAIL read_ledg: got %h, want 000000a5", d);
    end
    n_cmp++;
    // Simultaneous store and load returns the pre-write value.
    @(negedge clk);
    bus.we = 1'b1; bus.re = 1'b1; bus.addr = A_LEDG; bus.wdata = 32'h5A;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
    if (bus.rdata !== 32'hA5) begin
      n_err++; $display("FAIL rw_same_rdata: got %h, want 000000a5", bus.rdata);
    end
    n_cmp++;
    if (ledg_out !== 8'h5A) begin
      n_err++; $display("FAIL rw_same_write: got %h, want 5a", ledg_out);
    end
    n_cmp++;
    @(negedge clk);
    if (bus.rdata !== 32'hA5) begin
      n_err++; $display("FAIL rdata_hold: got %h, want 000000a5", bus.rdata);
    end
    n_cmp++;
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    @(negedge clk);
    key_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(A_KEY, d);
    if (d !== 32'h0) begin
      n_err++; $display("FAIL glitch_rejected: got %h, want 00000000", d);
    end
    n_cmp++;
    @(negedge clk);
    key_in[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dut.key_db[0] !== (k >= 6)) begin
        n_err++; $display("FAIL debounce_timing cycle %0d: got %b, want %b", k, dut.key_db[0], (k >= 6));
      end
      n_cmp++;
    end
    bus_read(A_KEY, d);
    if (d !== 32'h11) begin
      n_err++; $display("FAIL key_read_first: got %h, want 00000011", d);
    end
    n_cmp++;
    bus_read(A_KEY, d);
    if (d !== 32'h01) begin
      n_err++; $display("FAIL key_read_second: got %h, want 00000001", d);
    end
    n_cmp++;
    @(negedge clk);
    key_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(A_KEY, d);
    if (d !== 32'h0) begin
      n_err++; $display("FAIL key_release: got %h, want 00000000", d);
    end
    n_cmp++;
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    @(negedge clk);
    key_in[2] = 1'b0;
    repeat (5) @(negedge clk);
    // This read is sampled on the same edge that accepts the press.
    bus.re = 1'b1; bus.addr = A_KEY;
    @(negedge clk);
    bus.re = 1'b0;
    if (bus.rdata !== 32'h0) begin
      n_err++; $display("FAIL set_wins_old: got %h, want 00000000", bus.rdata);
    end
    n_cmp++;
    bus_read(A_KEY, d);
    if (d !== 32'h44) begin
      n_err++; $display("FAIL set_wins_new: got %h, want 00000044", d);
    end
    n_cmp++;
    key_in[2] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_switches_decode();
    logic [31:0] d;
    @(negedge clk);
    sw_in = 10'h2AA;
    repeat (8) @(negedge clk);
    bus_read(A_SW, d);
    if (d !== 32'h2AA) begin
      n_err++; $display("FAIL read_sw: got %h, want 000002aa", d);
    end
    n_cmp++;
    @(negedge clk);
    bus.re = 1'b1; bus.addr = A_GAP;
    #1;
    if (bus.sel !== 1'b0) begin
      n_err++; $display("FAIL sel_gap: got %b, want 0", bus.sel);
    end
    n_cmp++;
    @(negedge clk);
    bus.re = 1'b0;
    if (bus.rdata !== 32'h0) begin
      n_err++; $display("FAIL read_gap: got %h, want 00000000", bus.rdata);
    end
    n_cmp++;
    bus.addr = A_SW;
    #1;
    if (bus.sel !== 1'b1) begin
      n_err++; $display("FAIL sel_sw: got %b, want 1", bus.sel);
    end
    n_cmp++;
    bus_write(A_SW, 32'hFFFF_FFFF);
    bus_write(A_KEY, 32'hFFFF_FFFF);
    bus_write(A_GAP, 32'hFFFF_FFFF);
    if ({hex_out, ledr_out, ledg_out} !== {16'hABCD, 10'h3FF, 8'h5A}) begin
      n_err++; $display("FAIL ro_write: got hex=%h ledr=%h ledg=%h, want abcd 3ff 5a", hex_out, ledr_out, ledg_out);
    end
    n_cmp++;
    bus_read(A_SW, d);
    if (d !== 32'h2AA) begin
      n_err++; $display("FAIL sw_after_write: got %h, want 000002aa", d);
    end
    n_cmp++;
  endtask

  initial begin
    reset     = 1'b0;
    key_in    = 4'hF;
    sw_in     = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    test_reset();
    test_store_load();
    test_debounce();
    test_set_wins();
    test_switches_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
